// File: rtl/spi_reg_bank_pkg.sv
// Shared types for the SPI register bank.
// FSM encoding and frame geometry helper.
package spi_reg_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  function automatic int frame_w(int aw, int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// Multi-flop input synchroniser with edge detect.
// Edges come from the last synced sample and its delayed copy.
module spi_reg_bank_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_LVL}};
      prev_q <= RST_LVL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with register bank, clk-domain sampled.
// Frame: rw, addr, data, MSB first; reads shift out on cipo.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_strobe_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic                       frame_err_o
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CMD_CNT = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] FRM_CNT = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]  N_REGS  = (ADDR_W+1)'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_edges;

  spi_reg_bank_sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n resets to "selected" so a frame live across reset is parked
  spi_reg_bank_sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_cs (
    .clk(clk), .rst(rst), .d(cs_n),
    .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_reg_bank_sync_edge #(.STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_copi (
    .clk(clk), .rst(rst), .d(copi),
    .lvl(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  assign unused_edges = ^{sclk_lvl, cs_rise, cs_fall, copi_rise, copi_fall};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sin_q, sin_d, sin_shift;
  logic [DATA_W-1:0]  sout_q, sout_d, rd_data;
  logic               rd_q, rd_d;
  logic               armed_q;
  logic               reg_we, err_d;
  logic [ADDR_W-1:0]  cmd_addr, frm_addr;
  logic               cmd_rw, cmd_ok, frm_rw, frm_ok;

  assign sin_shift = {sin_q[FRAME_W-2:0], copi_lvl};
  assign cmd_rw    = sin_shift[CMD_W-1];
  assign cmd_addr  = sin_shift[ADDR_W-1:0];
  assign cmd_ok    = {1'b0, cmd_addr} < N_REGS;
  assign frm_rw    = sin_q[FRAME_W-1];
  assign frm_addr  = sin_q[FRAME_W-2 -: ADDR_W];
  assign frm_ok    = {1'b0, frm_addr} < N_REGS;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_addr == ADDR_W'(k)) rd_data = regs_o[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sin_d   = sin_q;
    sout_d  = sout_q;
    rd_d    = rd_q;
    reg_we  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!cs_lvl) state_d = armed_q ? ST_CMD : ST_HOLD;
      end
      ST_CMD: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          sin_d = sin_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CMD_CNT) begin
            state_d = ST_DATA;
            rd_d    = !cmd_rw;
            sout_d  = (!cmd_rw && cmd_ok) ? rd_data : '0;
          end
        end
      end
      ST_DATA: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          sin_d = sin_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == FRM_CNT) state_d = ST_COMMIT;
        end else if (sclk_fall) begin
          sout_d = {sout_q[DATA_W-2:0], 1'b0};
        end
      end
      ST_COMMIT: begin
        state_d = ST_HOLD;
        if (frm_rw) begin
          reg_we = frm_ok;
          err_d  = !frm_ok;
        end
      end
      ST_HOLD: begin
        if (cs_lvl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      rd_q        <= 1'b0;
      armed_q     <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      frame_err_o <= 1'b0;
      regs_o      <= {NUM_REGS{RST_VAL}};
    end else begin
      cnt_q       <= cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      rd_q        <= rd_d;
      armed_q     <= armed_q | cs_lvl;
      wr_strobe_o <= reg_we;
      frame_err_o <= err_d;
      if (reg_we) begin
        wr_addr_o <= frm_addr;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (frm_addr == ADDR_W'(k))
            regs_o[k*DATA_W +: DATA_W] <= sin_q[DATA_W-1:0];
        end
      end
    end
  end

  assign cipo    = sout_q[DATA_W-1];
  assign cipo_oe = (state_q == ST_DATA) && rd_q;

endmodule
